rf_write_queue: RTL and testbench

Writer-side front end for the general register file write port (WE/A3/WD/W_PC). It accepts register write-back requests from two producers: the main pipeline W stage on port 0, and the late-completing multiply/divide or load unit on port 1. Requests are serialised in program order through a small in-order queue and presented to the register file at one write per cycle. A lookup port exposes pending, uncommitted writes to the D-stage forwarding logic.

---
 rtl/rf_write_queue_pkg.sv | 13 +
 rtl/rf_write_queue_if.sv | 34 +++
 rtl/rf_wq_fifo.sv | 96 +++++++++
 rtl/rf_write_queue.sv | 135 +++++++++++++
 tb/tb_rf_write_queue.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/rf_write_queue_pkg.sv
// Shared constants and entry layout for the register-file write queue.
package rf_write_queue_pkg;

   localparam int         RF_WQ_DEPTH_DEFAULT = 4;
   localparam logic [4:0] REG_ZERO            = 5'd0;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pc;
   } wq_entry_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// Producer handshakes, register-file write port, forwarding lookup and occupancy.
interface rf_write_queue_if #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1)
);
   logic          val0;
   logic          rdy0;
   logic [4:0]    addr0;
   logic [31:0]   data0;
   logic [31:0]   pc0;
   logic          val1;
   logic          rdy1;
   logic [4:0]    addr1;
   logic [31:0]   data1;
   logic [31:0]   pc1;
   logic          WE;
   logic [4:0]    A3;
   logic [31:0]   WD;
   logic [31:0]   W_PC;
   logic [4:0]    q_addr;
   logic          q_hit;
   logic [31:0]   q_data;
   logic [LW-1:0] level;

   modport master (
      output val0, addr0, data0, pc0, val1, addr1, data1, pc1, q_addr,
      input  rdy0, rdy1, WE, A3, WD, W_PC, q_hit, q_data, level
   );

   modport slave (
      input  val0, addr0, data0, pc0, val1, addr1, data1, pc1, q_addr,
      output rdy0, rdy1, WE, A3, WD, W_PC, q_hit, q_data, level
   );
endinterface

// File: rtl/rf_wq_fifo.sv
// Circular buffer with two ordered pushes (a older than b) and one pop per edge;
// exposes per-entry valid/addr/data so the top can scan pending writes.
module rf_wq_fifo
   import rf_write_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1),
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   push_a_i,
   input  wq_entry_t              entry_a_i,
   input  logic                   push_b_i,
   input  wq_entry_t              entry_b_i,
   input  logic                   pop_i,
   output wq_entry_t              head_o,
   output logic [PW-1:0]          head_ptr_o,
   output logic [LW-1:0]          level_o,
   output logic [DEPTH-1:0]       ent_vld_o,
   output logic [DEPTH-1:0][4:0]  ent_addr_o,
   output logic [DEPTH-1:0][31:0] ent_data_o
);

   wq_entry_t        mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [PW-1:0]    tail_b_s;
   logic [LW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;

   // Pointer, count and valid-bit next state; push b lands after push a.
   always_comb begin
      tail_b_s = tail_q + PW'(push_a_i);
      head_d   = head_q + PW'(pop_i);
      tail_d   = tail_q + PW'(push_a_i) + PW'(push_b_i);
      count_d  = count_q + LW'(push_a_i) + LW'(push_b_i) - LW'(pop_i);
      vld_d    = vld_q;
      if (pop_i) begin
         vld_d[head_q] = 1'b0;
      end else begin
         vld_d = vld_d;
      end
      if (push_a_i) begin
         vld_d[tail_q] = 1'b1;
      end else begin
         vld_d = vld_d;
      end
      if (push_b_i) begin
         vld_d[tail_b_s] = 1'b1;
      end else begin
         vld_d = vld_d;
      end
   end

   // Control state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Entry storage; contents are qualified by vld_q so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push_a_i) begin
         mem_q[tail_q] <= entry_a_i;
      end
      if (push_b_i) begin
         mem_q[tail_b_s] <= entry_b_i;
      end
   end

   // Flatten storage for the lookup scan.
   always_comb begin
      ent_addr_o = '0;
      ent_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_addr_o[i] = mem_q[i].addr;
         ent_data_o[i] = mem_q[i].data;
      end
   end

   assign head_o     = mem_q[head_q];
   assign head_ptr_o = head_q;
   assign level_o    = count_q;
   assign ent_vld_o  = vld_q;

endmodule

// File: rtl/rf_write_queue.sv
// Serialises two write-back producers into the single register-file write port,
// with an in-order queue and a forwarding lookup over uncommitted writes.
module rf_write_queue
   import rf_write_queue_pkg::*;
#(
   parameter int DEPTH = RF_WQ_DEPTH_DEFAULT,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input logic              clk,
   input logic              reset,
   rf_write_queue_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);

   wq_entry_t              entry0_s, entry1_s, head_s;
   wq_entry_t              out_q, out_d;
   logic                   we_q, we_d;
   logic [LW-1:0]          level_s, free_s;
   logic [PW-1:0]          head_ptr_s;
   logic [DEPTH-1:0]       ent_vld_s;
   logic [DEPTH-1:0][4:0]  ent_addr_s;
   logic [DEPTH-1:0][31:0] ent_data_s;
   logic                   nz0_s, nz1_s, rdy0_s, rdy1_s, acc0_s, acc1_s;
   logic                   push_a_s, push_b_s, pop_s;
   logic                   hit_s;
   logic [31:0]            qdata_s;

   assign entry0_s = {bus.addr0, bus.data0, bus.pc0};
   assign entry1_s = {bus.addr1, bus.data1, bus.pc1};

   // Ready from registered occupancy only; register-0 writes are always taken.
   always_comb begin
      free_s = LW'(DEPTH) - level_s;
      nz0_s  = (bus.addr0 != REG_ZERO);
      nz1_s  = (bus.addr1 != REG_ZERO);
      rdy0_s = !reset && ((free_s >= LW'(1)) || !nz0_s);
      rdy1_s = !reset && (!nz1_s || (free_s >= LW'(2)) ||
                          ((free_s >= LW'(1)) && !(bus.val0 && nz0_s)));
      acc0_s = bus.val0 && rdy0_s && nz0_s;
      acc1_s = bus.val1 && rdy1_s && nz1_s;
   end

   // Pop selection: queued head first, otherwise bypass the oldest arrival.
   always_comb begin
      pop_s    = 1'b0;
      push_a_s = acc0_s;
      push_b_s = acc1_s;
      we_d     = 1'b0;
      out_d    = '0;
      if (level_s != LW'(0)) begin
         pop_s = 1'b1;
         we_d  = 1'b1;
         out_d = head_s;
      end else if (acc0_s) begin
         we_d     = 1'b1;
         out_d    = entry0_s;
         push_a_s = 1'b0;
      end else if (acc1_s) begin
         we_d     = 1'b1;
         out_d    = entry1_s;
         push_b_s = 1'b0;
      end else begin
         we_d  = 1'b0;
         out_d = '0;
      end
   end

   rf_wq_fifo #(.DEPTH(DEPTH), .LW(LW), .PW(PW)) u_fifo (
      .clk_i      (clk),
      .reset_i    (reset),
      .push_a_i   (push_a_s),
      .entry_a_i  (entry0_s),
      .push_b_i   (push_b_s),
      .entry_b_i  (entry1_s),
      .pop_i      (pop_s),
      .head_o     (head_s),
      .head_ptr_o (head_ptr_s),
      .level_o    (level_s),
      .ent_vld_o  (ent_vld_s),
      .ent_addr_o (ent_addr_s),
      .ent_data_o (ent_data_s)
   );

   // Register-file write port registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q  <= 1'b0;
         out_q <= '0;
      end else begin
         we_q  <= we_d;
         out_q <= out_d;
      end
   end

   // Lookup: output register is oldest, then queue oldest-to-youngest; last match wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = head_ptr_s;
      hit_s   = 1'b0;
      qdata_s = 32'd0;
      if (we_q && (out_q.addr == bus.q_addr)) begin
         hit_s   = 1'b1;
         qdata_s = out_q.data;
      end else begin
         hit_s   = 1'b0;
      end
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_ptr_s + PW'(k);
         if (ent_vld_s[idx] && (ent_addr_s[idx] == bus.q_addr)) begin
            hit_s   = 1'b1;
            qdata_s = ent_data_s[idx];
         end else begin
            qdata_s = qdata_s;
         end
      end
      if (reset || (bus.q_addr == REG_ZERO)) begin
         hit_s   = 1'b0;
         qdata_s = 32'd0;
      end else begin
         qdata_s = qdata_s;
      end
   end

   assign bus.rdy0   = rdy0_s;
   assign bus.rdy1   = rdy1_s;
   assign bus.WE     = we_q;
   assign bus.A3     = out_q.addr;
   assign bus.WD     = out_q.data;
   assign bus.W_PC   = out_q.pc;
   assign bus.q_hit  = hit_s;
   assign bus.q_data = qdata_s;
   assign bus.level  = level_s;

endmodule

// File: tb/tb_rf_write_queue.sv
// Randomised scoreboard bench for rf_write_queue against a list-based reference model.
module tb_rf_write_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] pc;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rf_write_queue_if #(.DEPTH(DEPTH)) bus ();
   rf_write_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   wr_t pend[$];
   wr_t exp_q[$];
   wr_t m_out;
   bit  m_we = 1'b0;
   int  checks = 0;
   int  failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every cycle the write port is compared against the scoreboard.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (bus.WE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL commit_unexpected: got A3=%0h WD=%0h with no commit expected", bus.A3, bus.WD);
            end else begin
               e = exp_q.pop_front();
               chk("commit_a3", bus.A3, e.a);
               chk("commit_wd", bus.WD, e.d);
               chk("commit_pc", bus.W_PC, e.pc);
            end
         end else begin
            chk("idle_a3", bus.A3, 5'd0);
            chk("idle_wd", bus.WD, 32'd0);
            chk("idle_pc", bus.W_PC, 32'd0);
         end
      end
   end

   task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0, input logic [31:0] p0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1, input logic [31:0] p1,
                       input logic [4:0] qa, input bit rs, output bit r0, output bit r1);
      int  free;
      bit  hit;
      logic [31:0] qd;
      @(negedge clk);
      bus.val0 = v0; bus.addr0 = a0; bus.data0 = d0; bus.pc0 = p0;
      bus.val1 = v1; bus.addr1 = a1; bus.data1 = d1; bus.pc1 = p1;
      bus.q_addr = qa;
      reset = rs;
      #1;
      free = DEPTH - pend.size();
      r0 = !rs && (free >= 1 || a0 == 5'd0);
      r1 = !rs && (a1 == 5'd0 || free >= 2 || (free >= 1 && !(v0 && a0 != 5'd0)));
      hit = 1'b0;
      qd  = 32'd0;
      if (!rs && qa != 5'd0) begin
         for (int j = pend.size() - 1; j >= 0; j--) begin
            if (!hit && pend[j].a == qa) begin
               hit = 1'b1;
               qd  = pend[j].d;
            end
         end
         if (!hit && m_we && m_out.a == qa) begin
            hit = 1'b1;
            qd  = m_out.d;
         end
      end
      chk("rdy0", bus.rdy0, r0);
      chk("rdy1", bus.rdy1, r1);
      chk("level", bus.level, pend.size());
      chk("we", bus.WE, m_we);
      chk("q_hit", bus.q_hit, hit);
      chk("q_data", bus.q_data, qd);
      if (rs) begin
         pend.delete();
         m_we = 1'b0;
      end else begin
         if (v0 && r0 && a0 != 5'd0) pend.push_back('{a0, d0, p0});
         if (v1 && r1 && a1 != 5'd0) pend.push_back('{a1, d1, p1});
         if (pend.size() > 0) begin
            m_out = pend.pop_front();
            m_we  = 1'b1;
            exp_q.push_back(m_out);
         end else begin
            m_we = 1'b0;
         end
      end
   endtask

   initial begin
      bit r0, r1, h0, h1, v0, v1;
      logic [4:0]  a0, a1, qa;
      logic [31:0] d0, d1, p0, p1;
      reset = 1'b1;
      bus.val0 = 1'b0; bus.addr0 = 5'd0; bus.data0 = 32'd0; bus.pc0 = 32'd0;
      bus.val1 = 1'b0; bus.addr1 = 5'd0; bus.data1 = 32'd0; bus.pc1 = 32'd0;
      bus.q_addr = 5'd0;
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, r0, r1);
      step(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 1'b0, r0, r1);
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 1'b0, r0, r1);
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 1'b0, r0, r1);
      step(1'b1, 5'd3, 32'hA, 32'h4000, 1'b1, 5'd3, 32'hB, 32'h4004, 5'd3, 1'b0, r0, r1);
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 1'b0, r0, r1);
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 1'b0, r0, r1);
      h0 = 1'b0; h1 = 1'b0;
      v0 = 1'b0; v1 = 1'b0; a0 = 5'd0; a1 = 5'd0; d0 = 32'd0; d1 = 32'd0; p0 = 32'd0; p1 = 32'd0;
      for (int i = 0; i < 600; i++) begin
         if (!h0) begin
            v0 = ($urandom_range(0, 9) < 8);
            a0 = 5'($urandom_range(0, 7));
            d0 = $urandom;
            p0 = $urandom;
         end
         if (!h1) begin
            v1 = ($urandom_range(0, 9) < 8);
            a1 = 5'($urandom_range(0, 7));
            d1 = $urandom;
            p1 = $urandom;
         end
         qa = 5'($urandom_range(0, 7));
         step(v0, a0, d0, p0, v1, a1, d1, p1, qa, (i == 300 || i == 450), r0, r1);
         h0 = v0 && !r0;
         h1 = v1 && !r1;
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'($urandom_range(0, 7)), 1'b0, r0, r1);
      end
      @(negedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
